hcp_lp_sorter: RTL and testbench

- Sits directly downstream of the hash-challenge-parse stage, which delivers a packed 20-bit list of four 5-bit party indices (first-extracted index in the MSBs).
- Captures that list, sorts it ascending with a sequential odd-even transposition network, and removes duplicates.
- Streams the unique indices one per handshake to the opening/selection stage.
- Also exports a 16-bit membership mask and the unique count.

---
 rtl/hcp_lp_sorter.sv | 149 ++++++++++++++
 tb/tb_hcp_lp_sorter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/hcp_lp_sorter.sv
// Captures a packed list of party indices, sorts it ascending with an odd-even
// transposition network, drops duplicates and streams the unique indices downstream.
module hcp_lp_sorter #(
  parameter int N  = 4,
  parameter int FW = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            lp_valid,
  input  logic [N*FW-1:0] lp_in,
  output logic            lp_ready,
  output logic            idx_valid,
  output logic [3:0]      idx_out,
  output logic            idx_last,
  input  logic            idx_ready,
  output logic [15:0]     mask,
  output logic [2:0]      num_unique,
  output logic            range_err,
  output logic            done
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SORT, S_EMIT, S_DONE} state_t;

  state_t        state;
  logic [3:0]    arr    [N];
  logic [3:0]    cap    [N];
  logic [3:0]    arr_sw [N];
  logic [PW-1:0] cnt;
  logic [PW-1:0] ptr;
  logic [PW-1:0] nptr;
  logic [FW-1:0] fld;
  logic [15:0]   mask_next;
  logic          err_next;
  logic [2:0]    num_next;
  logic [N-1:0]  uniq_cur;
  logic [N-1:0]  last_cur;
  logic          seen;

  // Field 0 sits in the MSBs; an out-of-range field keeps only its low 4 bits.
  always_comb begin
    cap       = '{default: 4'd0};
    mask_next = '0;
    err_next  = 1'b0;
    fld       = '0;
    for (int k = 0; k < N; k++) begin
      fld                = lp_in[(N-k)*FW-1 -: FW];
      cap[k]             = fld[3:0];
      mask_next[fld[3:0]] = 1'b1;
      err_next           = err_next | fld[FW-1];
    end
  end

  // One transposition phase per cycle; cnt parity selects the pair alignment.
  always_comb begin
    arr_sw = arr;
    for (int k = 0; k < N-1; k++) begin
      if ((((k % 2) == 1) == cnt[0]) && (arr[k+1] < arr[k])) begin
        arr_sw[k]   = arr[k+1];
        arr_sw[k+1] = arr[k];
      end
    end
    num_next = 3'd1;
    for (int k = 1; k < N; k++) begin
      if (arr_sw[k] != arr_sw[k-1]) num_next = num_next + 3'd1;
    end
  end

  always_comb begin
    nptr        = ptr + PW'(1);
    uniq_cur    = '0;
    last_cur    = '0;
    seen        = 1'b0;
    uniq_cur[0] = 1'b1;
    for (int k = 1; k < N; k++) uniq_cur[k] = (arr[k] != arr[k-1]);
    for (int k = N-1; k >= 0; k--) begin
      last_cur[k] = uniq_cur[k] & ~seen;
      seen        = seen | uniq_cur[k];
    end
  end

  // Output stream: a transfer happens on a rising edge where idx_valid & idx_ready;
  // idx_out/idx_last stay frozen while idx_valid is high and idx_ready is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      arr        <= '{default: 4'd0};
      cnt        <= '0;
      ptr        <= '0;
      lp_ready   <= 1'b0;
      idx_valid  <= 1'b0;
      idx_out    <= 4'd0;
      idx_last   <= 1'b0;
      mask       <= 16'd0;
      num_unique <= 3'd0;
      range_err  <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          lp_ready <= 1'b1;
          if (lp_valid && lp_ready) begin
            arr       <= cap;
            mask      <= mask_next;
            range_err <= err_next;
            ptr       <= '0;
            cnt       <= '0;
            lp_ready  <= 1'b0;
            state     <= S_SORT;
          end
        end
        S_SORT: begin
          arr <= arr_sw;
          cnt <= cnt + PW'(1);
          if (cnt == PW'(N-1)) begin
            num_unique <= num_next;
            ptr        <= '0;
            idx_valid  <= 1'b1;
            idx_out    <= arr_sw[0];
            idx_last   <= (num_next == 3'd1);
            state      <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (idx_valid && idx_ready && idx_last) begin
            idx_valid <= 1'b0;
            idx_last  <= 1'b0;
            done      <= 1'b1;
            state     <= S_DONE;
          end else if (!idx_valid || idx_ready) begin
            // A duplicate slot loads with idx_valid low, costing one bubble.
            ptr       <= nptr;
            idx_valid <= uniq_cur[nptr];
            idx_out   <= arr[nptr];
            idx_last  <= uniq_cur[nptr] & last_cur[nptr];
          end
        end
        S_DONE: begin
          done     <= 1'b0;
          lp_ready <= 1'b1;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hcp_lp_sorter.sv
// Directed and random lists for hcp_lp_sorter, compared against a counting-sort
// reference of the unique index stream, mask, count and range flag.
module tb_hcp_lp_sorter;
  localparam int N  = 4;
  localparam int FW = 5;

  logic            clk = 1'b0;
  logic            reset;
  logic            lp_valid;
  logic [N*FW-1:0] lp_in;
  logic            lp_ready;
  logic            idx_valid;
  logic [3:0]      idx_out;
  logic            idx_last;
  logic            idx_ready;
  logic [15:0]     mask;
  logic [2:0]      num_unique;
  logic            range_err;
  logic            done;

  int checks = 0;
  int errors = 0;

  logic [3:0]  exp_q[$];
  int          exp_slot_q[$];
  logic [15:0] exp_mask;
  logic [2:0]  exp_num;
  logic        exp_err;

  hcp_lp_sorter #(.N(N), .FW(FW)) dut (
    .clk(clk), .reset(reset), .lp_valid(lp_valid), .lp_in(lp_in), .lp_ready(lp_ready),
    .idx_valid(idx_valid), .idx_out(idx_out), .idx_last(idx_last), .idx_ready(idx_ready),
    .mask(mask), .num_unique(num_unique), .range_err(range_err), .done(done)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: count occurrences of each low-4-bit value, then walk 0..15.
  task automatic model(input logic [N*FW-1:0] list);
    int          cnt[16];
    int          slot;
    logic [FW-1:0] v;
    exp_q.delete();
    exp_slot_q.delete();
    exp_mask = '0;
    exp_err  = 1'b0;
    for (int u = 0; u < 16; u++) cnt[u] = 0;
    for (int k = 0; k < N; k++) begin
      v = list[(N-k)*FW-1 -: FW];
      exp_err = exp_err | v[FW-1];
      cnt[v[3:0]]++;
    end
    slot = 0;
    for (int u = 0; u < 16; u++) begin
      if (cnt[u] > 0) begin
        exp_q.push_back(4'(u));
        exp_slot_q.push_back(slot);
        exp_mask[u] = 1'b1;
        slot += cnt[u];
      end
    end
    exp_num = 3'(exp_q.size());
  endtask

  // mode 0: ready always high, 1: ready toggles with lp_valid pokes, 2: random ready
  task automatic run_list(input logic [N*FW-1:0] list, input int mode, input string name);
    int         cyc;
    int         first_valid;
    int         slot;
    bit         fin;
    bit         stall;
    logic [3:0] prev_out;
    logic       prev_last;
    logic [3:0] e;
    model(list);
    cyc = 0;
    while (!lp_ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk($sformatf("%s_lp_ready_idle", name), 32'(lp_ready), 32'd1);
    lp_valid = 1'b1;
    lp_in    = list;
    @(negedge clk);
    lp_valid = 1'b0;
    chk($sformatf("%s_lp_ready_busy", name), 32'(lp_ready), 32'd0);
    cyc = 1;
    first_valid = 0;
    fin = 1'b0;
    stall = 1'b0;
    prev_out = '0;
    prev_last = 1'b0;
    while (!fin && cyc < 60) begin
      if (stall) begin
        chk($sformatf("%s_stall_valid", name), 32'(idx_valid), 32'd1);
        chk($sformatf("%s_stall_out", name), 32'(idx_out), 32'(prev_out));
        chk($sformatf("%s_stall_last", name), 32'(idx_last), 32'(prev_last));
      end
      if (idx_valid && first_valid == 0) begin
        first_valid = cyc;
        chk($sformatf("%s_latency", name), 32'(cyc), 32'd5);
        chk($sformatf("%s_mask", name), 32'(mask), 32'(exp_mask));
        chk($sformatf("%s_num", name), 32'(num_unique), 32'(exp_num));
        chk($sformatf("%s_range_err", name), 32'(range_err), 32'(exp_err));
      end
      case (mode)
        0:       idx_ready = 1'b1;
        1:       idx_ready = cyc[0];
        default: idx_ready = 1'($urandom_range(0, 1));
      endcase
      if (mode == 1) begin
        lp_valid = ~cyc[0];
        lp_in    = ~list;
        chk($sformatf("%s_lp_ready_emit", name), 32'(lp_ready), 32'd0);
      end
      if (idx_valid && idx_ready) begin
        if (exp_q.size() == 0) begin
          chk($sformatf("%s_extra_index", name), 32'(idx_out), 32'hffff);
        end else begin
          e    = exp_q.pop_front();
          slot = exp_slot_q.pop_front();
          chk($sformatf("%s_idx_out", name), 32'(idx_out), 32'(e));
          chk($sformatf("%s_idx_last", name), 32'(idx_last), 32'(exp_q.size() == 0));
          if (mode == 0) chk($sformatf("%s_xfer_cycle", name), 32'(cyc), 32'(5 + slot));
        end
        if (idx_last) fin = 1'b1;
      end
      stall     = idx_valid && !idx_ready;
      prev_out  = idx_out;
      prev_last = idx_last;
      @(negedge clk);
      cyc++;
    end
    lp_valid  = 1'b0;
    idx_ready = 1'b0;
    chk($sformatf("%s_finished", name), 32'(fin), 32'd1);
    chk($sformatf("%s_left_over", name), 32'(exp_q.size()), 32'd0);
    chk($sformatf("%s_done_pulse", name), 32'(done), 32'd1);
    @(negedge clk);
    chk($sformatf("%s_done_clear", name), 32'(done), 32'd0);
    chk($sformatf("%s_ready_again", name), 32'(lp_ready), 32'd1);
    chk($sformatf("%s_valid_idle", name), 32'(idx_valid), 32'd0);
    chk($sformatf("%s_mask_hold", name), 32'(mask), 32'(exp_mask));
    chk($sformatf("%s_num_hold", name), 32'(num_unique), 32'(exp_num));
    chk($sformatf("%s_err_hold", name), 32'(range_err), 32'(exp_err));
  endtask

  initial begin
    logic [N*FW-1:0] list;
    logic [FW-1:0]   f;
    int              cyc;
    reset     = 1'b1;
    lp_valid  = 1'b0;
    lp_in     = '0;
    idx_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_lp_ready", 32'(lp_ready), 32'd0);
    chk("rst_idx_valid", 32'(idx_valid), 32'd0);
    chk("rst_idx_out", 32'(idx_out), 32'd0);
    chk("rst_idx_last", 32'(idx_last), 32'd0);
    chk("rst_mask", 32'(mask), 32'd0);
    chk("rst_num", 32'(num_unique), 32'd0);
    chk("rst_range_err", 32'(range_err), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    chk("rel_lp_ready_low", 32'(lp_ready), 32'd0);
    @(negedge clk);
    chk("rel_lp_ready_high", 32'(lp_ready), 32'd1);

    run_list({5'd3, 5'd12, 5'd3, 5'd0}, 0, "dup");
    run_list({5'd15, 5'd9, 5'd4, 5'd1}, 0, "rev");
    run_list({4{5'd7}}, 0, "all7");
    run_list({5'd15, 5'd9, 5'd4, 5'd1}, 1, "toggle");
    run_list({5'd18, 5'd2, 5'd5, 5'd6}, 0, "range");

    for (int i = 0; i < 25; i++) begin
      for (int k = 0; k < N; k++) begin
        f = {1'($urandom_range(0, 3) == 0), 4'($urandom_range(0, (i % 2 == 0) ? 5 : 15))};
        list[(N-k)*FW-1 -: FW] = f;
      end
      run_list(list, int'($urandom_range(0, 2)), $sformatf("rand%0d", i));
    end

    // Reset in the middle of an emit stream.
    model({5'd15, 5'd9, 5'd4, 5'd1});
    while (!lp_ready) @(negedge clk);
    lp_valid = 1'b1;
    lp_in    = {5'd15, 5'd9, 5'd4, 5'd1};
    @(negedge clk);
    lp_valid  = 1'b0;
    idx_ready = 1'b1;
    cyc = 1;
    while (cyc < 6) begin
      @(negedge clk);
      cyc++;
    end
    chk("mid_emit_valid", 32'(idx_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("abort_idx_valid", 32'(idx_valid), 32'd0);
    chk("abort_mask", 32'(mask), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_lp_ready", 32'(lp_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    chk("abort_rel_ready_low", 32'(lp_ready), 32'd0);
    @(negedge clk);
    chk("abort_rel_ready_high", 32'(lp_ready), 32'd1);
    for (int i = 0; i < 10; i++) begin
      chk("abort_no_stream", 32'(idx_valid), 32'd0);
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
